// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan driver.
// Segment patterns are stored active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int N_DIGITS = 4;
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Converts an active-low pattern to the board polarity.
  function automatic logic [6:0] to_polarity(input logic active_low, input logic [6:0] value);
    return active_low ? value : ~value;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex.sv
// Combinational hex-nibble to seven-segment decoder.
// Output is the active-low pattern; polarity is applied by the caller.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG7_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a valid/ready input.
// New values are latched into a pending slot and only shown from a frame boundary on.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  dp_i,
  input  logic        blank_lz_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_p0;
  logic [1:0]       idx_p0;
  logic             tc;
  logic             frame_end;

  logic [15:0] pend_data;
  logic [3:0]  pend_dp;
  logic [15:0] disp_data;
  logic [3:0]  disp_dp;

  logic [3:0] nib;
  logic [6:0] hex_seg;
  logic       zero_above;
  logic       blank;
  logic [6:0] seg_p0;
  logic [3:0] an_onehot;

  assign tc        = (cnt_p0 == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = tc && (idx_p0 == 2'(N_DIGITS - 1));

  // Stage 0: refresh timing and digit scan index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (tc) begin
      cnt_p0 <= '0;
      idx_p0 <= idx_p0 + 2'd1;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // ready_o doubles as the pending-empty flag; the two update paths are exclusive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_o   <= 1'b1;
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else if (valid_i && ready_o) begin
      pend_data <= data_i;
      pend_dp   <= dp_i;
      ready_o   <= 1'b0;
    end else if (frame_end && !ready_o) begin
      disp_data <= pend_data;
      disp_dp   <= pend_dp;
      ready_o   <= 1'b1;
    end
  end

  assign nib = disp_data[{idx_p0, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nibble (nib),
    .seg    (hex_seg)
  );

  // A digit is a leading zero when it and every higher nibble are zero
  always_comb begin
    zero_above = 1'b0;
    unique case (idx_p0)
      2'd0: zero_above = 1'b0;
      2'd1: zero_above = (disp_data[15:4] == 12'h000);
      2'd2: zero_above = (disp_data[15:8] == 8'h00);
      2'd3: zero_above = (disp_data[15:12] == 4'h0);
    endcase
  end

  assign blank     = blank_lz_i && zero_above;
  assign seg_p0    = blank ? SEG7_BLANK : hex_seg;
  assign an_onehot = 4'b0001 << idx_p0;

  // Stage 1: registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_o  <= ACTIVE_LOW ? 4'hF : 4'h0;
      seg_o <= to_polarity(ACTIVE_LOW, SEG7_BLANK);
      dp_o  <= ACTIVE_LOW;
    end else begin
      an_o  <= ACTIVE_LOW ? ~an_onehot : an_onehot;
      seg_o <= to_polarity(ACTIVE_LOW, seg_p0);
      dp_o  <= ACTIVE_LOW ? ~disp_dp[idx_p0] : disp_dp[idx_p0];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver with a short refresh period.
// Expected outputs come from a transfer log and frame arithmetic, not a copy of the RTL.
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int FR = 4 * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  dp_i = '0;
  logic        blank_lz_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .dp_i       (dp_i),
    .blank_lz_i (blank_lz_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .an_o       (an_o)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Transfer log: edge number (since reset release) and payload of every handshake
  int          ecnt = 0;
  int          ntr = 0;
  logic        xfer = 1'b0;
  logic        blank_e = 1'b0;
  int          tr_edge [64];
  logic [15:0] tr_data [64];
  logic [3:0]  tr_dp   [64];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecnt <= 0;
      ntr  <= 0;
      xfer <= 1'b0;
    end else begin
      ecnt    <= ecnt + 1;
      blank_e <= blank_lz_i;
      xfer    <= valid_i && ready_o;
      if (valid_i && ready_o && ntr < 64) begin
        tr_edge[ntr] <= ecnt + 1;
        tr_data[ntr] <= data_i;
        tr_dp[ntr]   <= dp_i;
        ntr          <= ntr + 1;
      end
    end
  end

  // A value accepted at edge t is shown from the first frame boundary strictly after t
  function automatic int shown_from(input int t);
    return (t / FR + 1) * FR;
  endfunction

  task automatic model_outputs(input int e, output logic [3:0] ea, output logic [6:0] es,
                               output logic ed, output logic er);
    int k;
    int fstart;
    logic [15:0] v;
    logic [3:0]  d;
    logic [15:0] above;
    er = 1'b1;
    if (ntr > 0 && tr_edge[ntr-1] <= e && shown_from(tr_edge[ntr-1]) > e) er = 1'b0;
    if (e == 0) begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1;
    end else begin
      k = ((e - 1) / RD) % 4;
      fstart = ((e - 1) / FR) * FR;
      v = 16'h0; d = 4'h0;
      for (int i = 0; i < ntr; i++)
        if (shown_from(tr_edge[i]) <= fstart) begin v = tr_data[i]; d = tr_dp[i]; end
      above = v >> (4 * k);
      ea = ~(4'b0001 << k);
      es = (blank_e && k > 0 && above == 16'h0) ? 7'h7F : hex_tab[(v >> (4 * k)) & 16'hF];
      ed = ~d[k];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] ea; logic [6:0] es; logic ed, er;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold an=%h seg=%h dp=%b rdy=%b exp F/7F/1/1", an_o, seg_o, dp_o, ready_o);
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      model_outputs(ecnt, ea, es, ed, er);
      checks++;
      if (an_o !== ea || seg_o !== es) begin
        errors++;
        $display("FAIL reset_scan e=%0d an=%h seg=%h exp an=%h seg=%h", ecnt, an_o, seg_o, ea, es);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] ea; logic [6:0] es; logic ed, er;
    do_reset();
    data_i = 16'h1234; dp_i = 4'b0100; valid_i = 1'b1; blank_lz_i = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      model_outputs(ecnt, ea, es, ed, er);
      checks++;
      if (ready_o !== er) begin errors++; $display("FAIL basic_ready e=%0d got %b exp %b", ecnt, ready_o, er); end
      checks++;
      if (an_o !== ea || seg_o !== es || dp_o !== ed) begin
        errors++;
        $display("FAIL basic_out e=%0d an=%h seg=%h dp=%b exp %h %h %b", ecnt, an_o, seg_o, dp_o, ea, es, ed);
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] ea; logic [6:0] es; logic ed, er;
    logic [15:0] vals [2] = '{16'h0040, 16'h0000};
    for (int t = 0; t < 2; t++) begin
      do_reset();
      data_i = vals[t]; dp_i = 4'b0000; valid_i = 1'b1; blank_lz_i = 1'b1;
      for (int c = 0; c < 36; c++) begin
        @(negedge clk);
        valid_i = 1'b0;
        model_outputs(ecnt, ea, es, ed, er);
        checks++;
        if (an_o !== ea || seg_o !== es || dp_o !== ed) begin
          errors++;
          $display("FAIL blank_%h e=%0d an=%h seg=%h dp=%b exp %h %h %b", vals[t], ecnt, an_o, seg_o, dp_o, ea, es, ed);
        end
      end
    end
    blank_lz_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea; logic [6:0] es; logic ed, er;
    int phase = 0;
    do_reset();
    data_i = 16'hABCD; dp_i = 4'b0001; valid_i = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (xfer && phase == 0) begin data_i = 16'hEF01; dp_i = 4'b1000; phase = 1; end
      else if (xfer && phase == 1) begin valid_i = 1'b0; phase = 2; end
      model_outputs(ecnt, ea, es, ed, er);
      checks++;
      if (ready_o !== er || an_o !== ea || seg_o !== es || dp_o !== ed) begin
        errors++;
        $display("FAIL b2b e=%0d rdy=%b an=%h seg=%h dp=%b exp %b %h %h %b", ecnt, ready_o, an_o, seg_o, dp_o, er, ea, es, ed);
      end
    end
    checks++;
    if (ntr !== 2 || (ntr == 2 && tr_edge[1] / FR == tr_edge[0] / FR)) begin
      errors++;
      $display("FAIL b2b_count transfers=%0d exp 2 in separate frames", ntr);
    end
  endtask

  task automatic test_boundary_xfer();
    logic [3:0] ea; logic [6:0] es; logic ed, er;
    int guard = 0;
    do_reset();
    while (ecnt != FR - 1 && guard < 2 * FR) begin @(negedge clk); guard++; end
    data_i = 16'h5A5A; dp_i = 4'b0010; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (ntr !== 1 || tr_edge[0] !== FR) begin
      errors++;
      $display("FAIL boundary_align transfers=%0d edge=%0d exp 1 at %0d", ntr, tr_edge[0], FR);
    end
    for (int c = 0; c < 2 * FR + 4; c++) begin
      @(negedge clk);
      model_outputs(ecnt, ea, es, ed, er);
      checks++;
      if (ready_o !== er || an_o !== ea || seg_o !== es || dp_o !== ed) begin
        errors++;
        $display("FAIL boundary e=%0d rdy=%b an=%h seg=%h dp=%b exp %b %h %h %b", ecnt, ready_o, an_o, seg_o, dp_o, er, ea, es, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ea; logic [6:0] es; logic ed, er;
    do_reset();
    data_i = 16'h9876; dp_i = 4'b1111; valid_i = 1'b1;
    repeat (6) begin @(negedge clk); valid_i = 1'b0; end
    rst = 1'b1;
    #1;
    checks++;
    if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid an=%h seg=%h dp=%b rdy=%b exp F/7F/1/1", an_o, seg_o, dp_o, ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      model_outputs(ecnt, ea, es, ed, er);
      checks++;
      if (an_o !== ea || seg_o !== es || dp_o !== ed || ready_o !== er) begin
        errors++;
        $display("FAIL reset_after e=%0d an=%h seg=%h dp=%b rdy=%b exp %h %h %b %b", ecnt, an_o, seg_o, dp_o, ready_o, ea, es, ed, er);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ea; logic [6:0] es; logic ed, er;
    do_reset();
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      model_outputs(ecnt, ea, es, ed, er);
      checks++;
      if (ready_o !== er || an_o !== ea || seg_o !== es || dp_o !== ed) begin
        errors++;
        $display("FAIL random e=%0d rdy=%b an=%h seg=%h dp=%b exp %b %h %h %b", ecnt, ready_o, an_o, seg_o, dp_o, er, ea, es, ed);
      end
      if (xfer) valid_i = 1'b0;
      if (!valid_i && $urandom_range(0, 3) == 0) begin
        data_i = 16'($urandom >> (4 * $urandom_range(0, 4) + 16));
        dp_i = 4'($urandom);
        valid_i = 1'b1;
      end
      if ($urandom_range(0, 31) == 0) blank_lz_i = ~blank_lz_i;
    end
    valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_back_to_back();
    test_boundary_xfer();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
